alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Multi-cycle control sequencer that drives the ALU control interface (`opcode`, `funcA`, `funcB`) and consumes the ALU's `overflow` flag.
- Fetches 9-bit instructions over a request/valid handshake and decodes them into ALU control fields.
- Sequences FETCH/EXEC/WB, latches a single condition flag, and resolves BNO/BOF branches against that flag.
- Sits between the instruction memory and the ALU/register file in the core.

Parameters:
- PC_W, 8, program counter width; PC wraps modulo 2^PC_W.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins execution at pc=0 from IDLE or HALTED.
- instr_req  output  1  high while in FETCH.
- instr_valid  input  1  instruction memory has presented the instruction at pc.
- instr  input  9  instruction word, sampled when instr_req && instr_valid.
- pc  output  PC_W  current instruction address.
- alu_opcode  output  3  to ALU opcode.
- alu_funcA  output  3  to ALU funcA.
- alu_funcB  output  1  to ALU funcB.
- alu_overflow  input  1  ALU overflow/compare flag, valid in WB.
- rf_we  output  1  register-file write enable for the ALU result.
- flag  output  1  latched condition flag.
- illegal  output  1  one-cycle pulse in WB for a reserved encoding.
- halted  output  1  high in HALTED.

Behaviour:
- Reset values: pc=0, state=IDLE, instr_req=0, alu_opcode/funcA/funcB=0, rf_we=0, flag=0, illegal=0, halted=0.
- Reset asserted at any time aborts the current instruction immediately; there is no partial writeback.

Decode (ir = latched instruction):
- op = ir[8:6].
- op=000: HALT.
- op=001: reserved. Treated as a NOP with the illegal pulse.
- op=010 ADD, 101 DIST: write result only.
- op=011 MATCH, 100 LT: write flag only.
- op=110, funcA=ir[5:3], funcB=ir[2]:
  - LSL 000: writes result and flag.
  - LSR 001, INCR 010, ZERO 101: write result.
  - AND1 011, EQZ 100: write flag.
  - 110 and 111: reserved. Treated as a NOP with the illegal pulse.
- op=111 branch: ir[5] selects BOF (1) or BNO (0).
  - Drive funcA=ir[5]?100:000 and funcB=ir[5].
  - off = sign-extended ir[4:0], range -16..+15.
- Ops other than 110/111 drive funcA=000, funcB=0.

FSM:
- IDLE: on start go to FETCH.
- FETCH: instr_req=1. Wait any number of cycles for instr_valid; on valid, latch ir and go to EXEC.
- EXEC: drive the ALU fields from ir (the ALU is clocked). Go to WB.
- WB: fields stay stable.
  - rf_we=1 for result ops.
  - flag <= alu_overflow at the WB edge for flag ops.
  - pc update:
    - BOF taken when flag=1; BNO taken when flag=0.
    - Taken branch: pc <= pc + off. Otherwise pc <= pc + 1.
    - Modulo 2^PC_W in both cases.
  - Branches read the flag value from before this WB.
  - Next state is FETCH; HALT goes to HALTED and pc is unchanged.
- HALTED: halted=1. On start, pc <= 0 and go to FETCH.

Boundary rules:
- Latency is at least 3 cycles per instruction (FETCH, EXEC, WB).
- start outside IDLE/HALTED is ignored.
- instr_valid outside FETCH is ignored.
- A branch with off=0 taken re-executes itself (legal).
- pc=2^PC_W-1 plus 1 wraps to 0; backward offsets wrap likewise.
- ALU fields return to 0 outside EXEC/WB.

Decomposition:
- alu_ctrl_pkg holds:
  - opcode localparams (OP_HALT, OP_ADD, OP_MATCH, OP_LT, OP_DIST, OP_GRP, OP_BR);
  - funcA localparams (F_LSL, F_LSR, F_INCR, F_AND1, F_EQZ, F_ZERO);
  - a state_t enum {IDLE, FETCH, EXEC, WB, HALTED}.
- One combinational sub-module, alu_op_classify: maps ir to funcA, funcB, wr_res, wr_flag, is_branch, is_halt, is_illegal.

Test Plan:
- ADD 9'b010_000000, instr_valid delayed 3 cycles -> instr_req held for 4 cycles, then EXEC, WB with rf_we=1 for exactly 1 cycle; pc 0->1.
- MATCH with alu_overflow=1 in WB, then BOF off=+4 at pc=1 -> flag=1, pc goes 1->5, alu_funcA=100, alu_funcB=1.
- LT with alu_overflow=0, then BNO off=-2 (5'b11110) at pc=0 -> pc wraps to 2^PC_W-2 = 254.
- op=110 funcA=111 -> illegal=1 for 1 cycle, rf_we=0, flag unchanged, pc+1.
- HALT -> halted=1 and pc is held; start while halted -> pc=0, instr_req=1 the next cycle.
- Reset asserted during EXEC of ADD -> all outputs at reset values asynchronously, with no rf_we pulse; start after release runs normally.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_pkg
//  Description : Shared encodings for the ALU control sequencer.
//                Holds the 3-bit opcode values, the 3-bit funcA values used
//                by the op=110 group, and the sequencer state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

    // Primary opcode field ir[8:6]; 3'b001 is reserved.
    localparam logic [2:0] OP_HALT  = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_MATCH = 3'b011;
    localparam logic [2:0] OP_LT    = 3'b100;
    localparam logic [2:0] OP_DIST  = 3'b101;
    localparam logic [2:0] OP_GRP   = 3'b110;
    localparam logic [2:0] OP_BR    = 3'b111;

    // funcA field ir[5:3] inside OP_GRP; 3'b110 and 3'b111 are reserved.
    localparam logic [2:0] F_LSL  = 3'b000;
    localparam logic [2:0] F_LSR  = 3'b001;
    localparam logic [2:0] F_INCR = 3'b010;
    localparam logic [2:0] F_AND1 = 3'b011;
    localparam logic [2:0] F_EQZ  = 3'b100;
    localparam logic [2:0] F_ZERO = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        HALTED = 3'd4
    } state_t;

endpackage : alu_ctrl_pkg
`default_nettype wire

// File: rtl/alu_op_classify.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_classify
//  Description : Combinational decode of a latched instruction into the ALU
//                function fields and the writeback / control class bits.
//  Ports       : i_ir          instruction bits [8:2] (offset bits unused)
//                o_funcA/B     ALU function fields
//                o_wr_res      op writes the ALU result to the register file
//                o_wr_flag     op loads the condition flag from alu_overflow
//                o_is_branch   BNO/BOF
//                o_is_halt     HALT
//                o_is_illegal  reserved encoding (executes as a NOP)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_classify
    import alu_ctrl_pkg::*;
(
    input  logic [8:2] i_ir,
    output logic [2:0] o_funcA,
    output logic       o_funcB,
    output logic       o_wr_res,
    output logic       o_wr_flag,
    output logic       o_is_branch,
    output logic       o_is_halt,
    output logic       o_is_illegal
);

    always_comb begin
        o_funcA      = 3'b000;
        o_funcB      = 1'b0;
        o_wr_res     = 1'b0;
        o_wr_flag    = 1'b0;
        o_is_branch  = 1'b0;
        o_is_halt    = 1'b0;
        o_is_illegal = 1'b0;

        case (i_ir[8:6])
            OP_HALT:          o_is_halt = 1'b1;
            OP_ADD, OP_DIST:  o_wr_res  = 1'b1;
            OP_MATCH, OP_LT:  o_wr_flag = 1'b1;
            OP_GRP: begin
                // Reserved group encodings still present their raw fields
                // to the ALU; only the writeback is suppressed.
                o_funcA = i_ir[5:3];
                o_funcB = i_ir[2];
                case (i_ir[5:3])
                    F_LSL: begin
                        o_wr_res  = 1'b1;
                        o_wr_flag = 1'b1;
                    end
                    F_LSR, F_INCR, F_ZERO: o_wr_res  = 1'b1;
                    F_AND1, F_EQZ:         o_wr_flag = 1'b1;
                    default:               o_is_illegal = 1'b1;
                endcase
            end
            OP_BR: begin
                // BOF asks the ALU for funcA=100/funcB=1, BNO for all zero.
                o_is_branch = 1'b1;
                o_funcA     = i_ir[5] ? 3'b100 : 3'b000;
                o_funcB     = i_ir[5];
            end
            default:          o_is_illegal = 1'b1;
        endcase
    end

endmodule : alu_op_classify
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : FETCH/EXEC/WB control sequencer for the ALU. Fetches 9-bit
//                instructions over a req/valid handshake, drives the ALU
//                control fields, latches the condition flag and resolves
//                BNO/BOF branches.
//  Ports       : clock, reset (async, active high), start (run pulse)
//                instr_req/instr_valid/instr  instruction fetch handshake
//                pc                           current instruction address
//                alu_opcode/funcA/funcB       ALU control fields
//                alu_overflow                 ALU flag, sampled in WB
//                rf_we, flag, illegal, halted status / control outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int PC_W = 8
)(
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    output logic            instr_req,
    input  logic            instr_valid,
    input  logic [8:0]      instr,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      alu_opcode,
    output logic [2:0]      alu_funcA,
    output logic            alu_funcB,
    input  logic            alu_overflow,
    output logic            rf_we,
    output logic            flag,
    output logic            illegal,
    output logic            halted
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [8:0]      ir_q, ir_d;
    logic            flag_q, flag_d;

    logic [2:0]      w_funcA;
    logic            w_funcB;
    logic            w_wr_res;
    logic            w_wr_flag;
    logic            w_is_branch;
    logic            w_is_halt;
    logic            w_is_illegal;
    logic            w_alu_active;
    logic            w_taken;
    logic [PC_W-1:0] w_off;

    alu_op_classify u_classify (
        .i_ir         (ir_q[8:2]),
        .o_funcA      (w_funcA),
        .o_funcB      (w_funcB),
        .o_wr_res     (w_wr_res),
        .o_wr_flag    (w_wr_flag),
        .o_is_branch  (w_is_branch),
        .o_is_halt    (w_is_halt),
        .o_is_illegal (w_is_illegal)
    );

    // Branch offset is a 5-bit two's-complement value; pc arithmetic wraps.
    assign w_off   = {{(PC_W-5){ir_q[4]}}, ir_q[4:0]};
    // flag_q still holds the pre-WB value, so branches see the old flag.
    assign w_taken = w_is_branch && (ir_q[5] ? flag_q : !flag_q);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flag_d  = flag_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = WB;
            WB: begin
                if (w_wr_flag) begin
                    flag_d = alu_overflow;
                end
                if (w_is_halt) begin
                    state_d = HALTED;
                end else begin
                    pc_d    = w_taken ? (pc_q + w_off) : (pc_q + 1'b1);
                    state_d = FETCH;
                end
            end
            HALTED: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flag_q  <= flag_d;
        end
    end

    // Outputs decode straight from state so reset clears them immediately.
    assign w_alu_active = (state_q == EXEC) || (state_q == WB);

    assign instr_req  = (state_q == FETCH);
    assign pc         = pc_q;
    assign alu_opcode = w_alu_active ? ir_q[8:6] : 3'b000;
    assign alu_funcA  = w_alu_active ? w_funcA   : 3'b000;
    assign alu_funcB  = w_alu_active && w_funcB;
    assign rf_we      = (state_q == WB) && w_wr_res;
    assign flag       = flag_q;
    assign illegal    = (state_q == WB) && w_is_illegal;
    assign halted     = (state_q == HALTED);

endmodule : alu_sequencer
`default_nettype wire
